// File: rtl/game_status_module.sv
// -----------------------------------------------------------------------------
// game_status_module
//
// Game-level controller for the Greedy Snake design (40 MHz pixel clock).
// Debounces the start key, tracks the one-hot game state START/PLAY/END and,
// while in END, times the blinking end screen.
//
// Ports
//   CLK_40M        in  1  system clock, rising edge
//   RST            in  1  synchronous, active-high reset
//   Key_start      in  1  raw start button, active-high, asynchronous
//   Hit_sig        in  1  collision indication from the play logic
//   Game_status    out 3  one-hot state: START=001, PLAY=010, END=100
//   Flash_sig      out 1  end-screen draw enable
//   Flash_over_sig out 1  one-cycle pulse when the blink sequence finishes
//   Restart_sig    out 1  one-cycle pulse to reinitialise the snake
// -----------------------------------------------------------------------------
module game_status_module #(
    parameter int DEBOUNCE_CYCLES   = 400_000,
    parameter int FLASH_HALF_CYCLES = 10_000_000,
    parameter int FLASH_TIMES       = 3
) (
    input  logic       CLK_40M,
    input  logic       RST,
    input  logic       Key_start,
    input  logic       Hit_sig,
    output logic [2:0] Game_status,
    output logic       Flash_sig,
    output logic       Flash_over_sig,
    output logic       Restart_sig
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HALF_W  = (FLASH_HALF_CYCLES > 1) ? $clog2(FLASH_HALF_CYCLES) : 1;
    localparam int PHASE_W = $clog2(2 * FLASH_TIMES);

    // Terminal counts: the debouncer accepts the new level on the edge at
    // which the mismatch has been seen for DEBOUNCE_CYCLES cycles.
    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HALF_W-1:0]  HALF_LAST  = HALF_W'(FLASH_HALF_CYCLES - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(2 * FLASH_TIMES - 1);

    typedef enum logic [2:0] {
        ST_START = 3'b001,
        ST_PLAY  = 3'b010,
        ST_END   = 3'b100
    } state_t;

    // ---------------------------------------------------------------------
    // Key path: two-flop synchroniser, debouncer, rising-edge detector
    // ---------------------------------------------------------------------
    logic            r_sync1;
    logic            r_sync2;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_key_db;
    logic            r_key_db_d;
    logic            w_start_pulse;

    always_ff @(posedge CLK_40M) begin
        if (RST) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_cnt   <= '0;
            r_key_db   <= 1'b0;
            r_key_db_d <= 1'b0;
        end else begin
            r_sync1    <= Key_start;
            r_sync2    <= r_sync1;
            r_key_db_d <= r_key_db;
            // Any cycle where the synced level agrees with the accepted
            // level restarts the stability window.
            if (r_sync2 != r_key_db) begin
                if (r_db_cnt == DB_LAST) begin
                    r_key_db <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DB_W'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // Only a fresh 0->1 of the debounced level starts a game, so a key that
    // is still held when END returns to START does nothing.
    assign w_start_pulse = r_key_db & ~r_key_db_d;

    // ---------------------------------------------------------------------
    // Game state machine with registered outputs
    // ---------------------------------------------------------------------
    state_t             r_state;
    logic [HALF_W-1:0]  r_half_cnt;
    logic [PHASE_W-1:0] r_phase_cnt;
    logic               r_flash;
    logic               r_flash_over;
    logic               r_restart;

    always_ff @(posedge CLK_40M) begin
        if (RST) begin
            r_state      <= ST_START;
            r_half_cnt   <= '0;
            r_phase_cnt  <= '0;
            r_flash      <= 1'b0;
            r_flash_over <= 1'b0;
            r_restart    <= 1'b0;
        end else begin
            // Pulses are one cycle wide by default.
            r_flash_over <= 1'b0;
            r_restart    <= 1'b0;
            case (r_state)
                ST_START: begin
                    r_flash <= 1'b0;
                    if (w_start_pulse) begin
                        r_state   <= ST_PLAY;
                        r_restart <= 1'b1;
                    end
                end

                ST_PLAY: begin
                    r_flash <= 1'b0;
                    if (Hit_sig) begin
                        // Blink timing starts from zero with the screen on.
                        r_state     <= ST_END;
                        r_flash     <= 1'b1;
                        r_half_cnt  <= '0;
                        r_phase_cnt <= '0;
                    end
                end

                ST_END: begin
                    if (r_half_cnt == HALF_LAST) begin
                        r_half_cnt <= '0;
                        if (r_phase_cnt == PHASE_LAST) begin
                            // Last half-period done: leave with screen off.
                            r_state      <= ST_START;
                            r_phase_cnt  <= '0;
                            r_flash      <= 1'b0;
                            r_flash_over <= 1'b1;
                        end else begin
                            r_phase_cnt <= r_phase_cnt + PHASE_W'(1);
                            r_flash     <= ~r_flash;
                        end
                    end else begin
                        r_half_cnt <= r_half_cnt + HALF_W'(1);
                    end
                end

                default: begin
                    // Corrupted encoding: recover quietly to START.
                    r_state     <= ST_START;
                    r_flash     <= 1'b0;
                    r_half_cnt  <= '0;
                    r_phase_cnt <= '0;
                end
            endcase
        end
    end

    assign Game_status    = r_state;
    assign Flash_sig      = r_flash;
    assign Flash_over_sig = r_flash_over;
    assign Restart_sig    = r_restart;

endmodule
